clkdiv_cfg_ctrl: RTL
====================

Name: clkdiv_cfg_ctrl

Overview:
- Configuration controller and arbiter that owns the enable and ratio inputs of one integer clock divider.
- Accepts ratio-change requests from two requesters (e.g. TX and RX prescale logic) and arbitrates them round-robin.
- Sequences each change glitch-safely: disable divider, settle, load ratio, re-enable, wait one output period, acknowledge.
- Sits in the reference-clock domain, directly in front of the divider.

Parameters:
- Width, 4, width of the ratio fields (requests and o_div_ratio).
- SETTLE, 2, number of cycles the divider is held disabled before the new ratio is loaded; legal range 1..15.
- DEF_RATIO, 2, ratio driven on o_div_ratio out of reset; must be non-zero.

Ports:
- i_ref_clk  in  1  reference clock; the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req0  in  1  requester 0 change request; level, held until o_ack0.
- i_ratio0  in  Width  requester 0 requested ratio; stable while i_req0 high.
- i_req1  in  1  requester 1 change request.
- i_ratio1  in  Width  requester 1 requested ratio.
- o_ack0  out  1  one-cycle completion pulse to requester 0.
- o_ack1  out  1  one-cycle completion pulse to requester 1.
- o_err  out  1  one-cycle pulse, coincident with the ack, when the request was rejected.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_clk_en  out  1  divider enable.
- o_div_ratio  out  Width  divider ratio.

Behaviour:
- All outputs are registered. i_rst_n is sampled on the rising edge of i_ref_clk.
- Reset (i_rst_n low at an edge) sets:
  - o_clk_en=0, o_div_ratio=DEF_RATIO.
  - o_ack0=o_ack1=o_err=0, o_busy=0.
  - state=IDLE, round-robin pointer=0, all counters=0.
- First edge after reset release: o_clk_en becomes 1.
- Reset mid-operation: the in-flight request is discarded and no ack is issued. o_div_ratio returns to DEF_RATIO.
- FSM states: IDLE, DRAIN, LOAD, LOCK, ACK.
- IDLE: o_clk_en=1, o_busy=0. On an edge with any request high, one requester is granted:
  - Only one request high: that requester wins.
  - Both high: the requester selected by the pointer wins.
  - The pointer then moves to the non-granted index. It updates only on a grant.
  - The winner's ratio is captured into an internal register.
- Granted-request decode:
  - Ratio 0: go to ACK with the reject flag set. o_div_ratio and o_clk_en are unchanged.
  - Ratio equal to the current o_div_ratio: fast path, go directly to ACK, no disable.
  - Otherwise: go to DRAIN, o_clk_en<=0, settle counter loaded.
- DRAIN: lasts exactly SETTLE cycles, with o_clk_en=0, then go to LOAD.
- LOAD: one cycle. o_div_ratio<=captured ratio, o_clk_en stays 0, then go to LOCK.
- LOCK: o_clk_en=1. Lasts exactly N cycles, where N is the captured ratio (ratio 1 gives 1 cycle, i.e. bypass). Then go to ACK.
- ACK: one cycle.
  - The granted requester's ack is 1.
  - o_err=1 only if the request was rejected.
  - Then return to IDLE.
- Cycle timing for a normal change, with IDLE sampling cycle c0:
  - o_clk_en is low during c1..c(SETTLE+1).
  - o_div_ratio holds the new value from c(SETTLE+1).
  - The ack is in cycle c(SETTLE+2+N).
- Fast path and reject: ack in c1.
- o_busy=1 in DRAIN, LOAD, LOCK and ACK.
- Requests arriving while busy are ignored until IDLE. Requests are level-sensitive, so a held request is serviced when the FSM returns to IDLE.
- Requester rule: drop req the cycle after its ack. A req still high in the IDLE cycle after ack is treated as a new request.
- The ungranted requester waits with no ack. At its next IDLE sample it wins if it is the only request, or because the pointer now selects it.
- Ratio changes on i_ratioX while its req is high are not captured after the grant.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles, release → o_clk_en=0, o_div_ratio=2 and o_busy=0 during reset; o_clk_en=1 from the first edge after release.
- Single change (SETTLE=2): i_req0=1, i_ratio0=6 sampled at c0 → o_clk_en=0 during c1..c3; o_div_ratio=6 from c3; o_ack0 pulse in c10; o_err=0; o_busy=1 during c1..c10.
- Contention: i_req0 and i_req1 rise in the same cycle with ratios 4 and 8, pointer=0, both held until acked → req0 acked first; o_div_ratio=4. Then req1 is granted at the next IDLE cycle, o_div_ratio=8, o_ack1 pulses. After a later double request, req0 is granted first again.
- Reject and fast path:
  - i_ratio1=0 → o_ack1 and o_err pulse together in c1; o_clk_en stays 1; o_div_ratio unchanged.
  - i_ratio0 equal to the current ratio → o_ack0 in c1; o_clk_en never drops.
- Bypass: i_ratio0=1 → LOCK lasts 1 cycle; ack in c5 with SETTLE=2.
- Reset mid-operation: assert i_rst_n=0 while in LOCK → no ack issued; next edge shows o_div_ratio=2, o_clk_en=0, o_busy=0.

Source files
------------

// File: rtl/clkdiv_cfg_ctrl.sv
// Configuration controller for one integer clock divider: arbitrates two ratio-change
// requesters round-robin and sequences each change as disable, settle, load, re-enable, lock, ack.
module clkdiv_cfg_ctrl #(
  parameter int Width     = 4,
  parameter int SETTLE    = 2,
  parameter int DEF_RATIO = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic [Width-1:0] i_ratio0,
  input  logic             i_req1,
  input  logic [Width-1:0] i_ratio1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_err,
  output logic             o_busy,
  output logic             o_clk_en,
  output logic [Width-1:0] o_div_ratio
);

  // Counter must hold both SETTLE-1 (up to 14) and ratio-1.
  localparam int CW = (Width > 4) ? Width : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_LOAD  = 3'd2,
    S_LOCK  = 3'd3,
    S_ACK   = 3'd4
  } state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             gnt_q;
  logic [Width-1:0] ratio_q;
  logic [CW-1:0]    cnt_q;
  logic             clk_en_q;
  logic [Width-1:0] div_ratio_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             err_q;
  logic             busy_q;

  logic             req_any_d;
  logic             gnt_d;
  logic [Width-1:0] sel_ratio_d;

  // Pointer only breaks ties; a lone request always wins.
  always_comb begin
    req_any_d   = i_req0 | i_req1;
    gnt_d       = (i_req0 & i_req1) ? ptr_q : i_req1;
    sel_ratio_d = gnt_d ? i_ratio1 : i_ratio0;
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      ratio_q     <= '0;
      cnt_q       <= '0;
      clk_en_q    <= 1'b0;
      div_ratio_q <= Width'(DEF_RATIO);
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_en_q <= 1'b1;
          busy_q   <= 1'b0;
          if (req_any_d) begin
            gnt_q   <= gnt_d;
            ptr_q   <= ~gnt_d;
            ratio_q <= sel_ratio_d;
            busy_q  <= 1'b1;
            if (sel_ratio_d == '0 || sel_ratio_d == div_ratio_q) begin
              // Reject or no-op change: acknowledge without touching the divider.
              state_q <= S_ACK;
              ack0_q  <= ~gnt_d;
              ack1_q  <= gnt_d;
              err_q   <= (sel_ratio_d == '0);
            end else begin
              state_q  <= S_DRAIN;
              clk_en_q <= 1'b0;
              cnt_q    <= CW'(SETTLE - 1);
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_q     <= S_LOAD;
            div_ratio_q <= ratio_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_LOAD: begin
          state_q  <= S_LOCK;
          clk_en_q <= 1'b1;
          cnt_q    <= CW'(ratio_q) - CW'(1);
        end
        S_LOCK: begin
          if (cnt_q == '0) begin
            state_q <= S_ACK;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = div_ratio_q;

endmodule
